spi_slave: RTL and testbench

- FPGA-side SPI mode-0 slave for the sniffer's PIC link.
- Receive path: oversamples sclk/mosi/cs on the system clock, assembles 1-byte short and 5-byte long commands, and presents each decoded command as a one-cycle strobe to the core.
- Transmit path: accepts 32-bit result words from the core, raises dataReady, and shifts the bytes out on miso as the PIC clocks dummy 0x7F bytes.

---
 rtl/spi_slave_if.sv | 29 ++
 rtl/spi_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus core-side command and transmit handshake for the PIC link slave.
// Latency: none (wiring only).
// Backpressure: tx_valid/tx_ready handshake on the transmit side; command strobes cannot be stalled.
interface spi_slave_if #(
    parameter int TX_BYTES_W = 3
) ();
    logic                  sclk;
    logic                  mosi;
    logic                  cs;
    logic                  miso;
    logic                  cmd_valid;
    logic [7:0]            cmd_opcode;
    logic [31:0]           cmd_data;
    logic                  tx_valid;
    logic [31:0]           tx_data;
    logic [TX_BYTES_W-1:0] tx_bytes;
    logic                  tx_ready;
    logic                  dataReady;

    modport slave (
        input  sclk, mosi, cs, tx_valid, tx_data, tx_bytes,
        output miso, cmd_valid, cmd_opcode, cmd_data, tx_ready, dataReady
    );

    modport master (
        output sclk, mosi, cs, tx_valid, tx_data, tx_bytes,
        input  miso, cmd_valid, cmd_opcode, cmd_data, tx_ready, dataReady
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave; oversampled 1/5-byte command receive, 32-bit word transmit on miso. Option macro: SPI_TIMEOUT_EN.
// Latency: cmd_valid one clock after the synchronized 8th sclk rise of the completing byte (~4 clocks after the pin edge).
// Backpressure: tx_ready low while a word is pending; commands are never stalled, fill bytes ignored while dataReady.
module spi_slave #(
    parameter int TX_BYTES_W = 3
`ifdef SPI_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    spi_slave_if.slave bus
);
    localparam logic [0:0] CMD_OPCODE = 1'b0;
    localparam logic [0:0] CMD_ARG    = 1'b1;
    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_ARM     = 2'd1;
    localparam logic [1:0] TX_SHIFT   = 2'd2;

    // Synchronizers; the third stage of sclk/cs is only for edge detection.
    logic [2:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    // Receive shifter.
    logic [6:0] rx_sr_q, rx_sr_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    // Command assembly.
    logic [0:0] cmd_state_q, cmd_state_d;
    logic [1:0] arg_idx_q, arg_idx_d;
    logic [7:0] pend_op_q, pend_op_d;
    logic [23:0] arg_q, arg_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_opcode_q, cmd_opcode_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    // Transmit.
    logic [1:0] tx_state_q, tx_state_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [1:0] tx_idx_q, tx_idx_d, tx_last_q, tx_last_d;
    logic [6:0] tx_sr_q, tx_sr_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       miso_q, miso_d, data_ready_q, data_ready_d;

    logic       sclk_rise, sclk_edge, cs_low, cs_fall, cs_rise, mosi_s, byte_done;
    logic [7:0] rx_byte, cur_byte;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_edge = sclk_sync_q[1] ^ sclk_sync_q[2];
    assign cs_low    = ~cs_sync_q[1];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign cur_byte  = tx_word_q[{tx_idx_q, 3'b000} +: 8];

`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;
    assign timeout_hit = (cmd_state_q == CMD_ARG) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Idle counter: restarts on any sclk edge, runs only while an argument is being collected.
    always_comb begin
        to_cnt_d = (cmd_state_q != CMD_ARG || sclk_edge) ? '0 : to_cnt_q + 1'b1;
    end

    // Idle counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`endif

    // Input synchronizer chains and bit/byte receive (partial byte dropped on cs rise).
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[1:0], bus.cs};
        mosi_sync_d = {mosi_sync_q[0], bus.mosi};
        rx_sr_d     = rx_sr_q;
        rx_cnt_d    = rx_cnt_q;
        byte_done   = 1'b0;
        if (cs_rise) begin
            rx_cnt_d = 3'd0;
        end else if (cs_low && sclk_rise) begin
            rx_sr_d   = rx_byte[6:0];
            rx_cnt_d  = rx_cnt_q + 3'd1;
            byte_done = (rx_cnt_q == 3'd7);
        end
    end

    // Command FSM: short opcodes strobe at once, long ones collect four argument bytes first.
    always_comb begin
        cmd_state_d  = cmd_state_q;
        arg_idx_d    = arg_idx_q;
        pend_op_d    = pend_op_q;
        arg_d        = arg_q;
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        cmd_data_d   = cmd_data_q;
        if (byte_done && !data_ready_q) begin
            if (cmd_state_q == CMD_OPCODE) begin
                if (!rx_byte[7]) begin
                    cmd_valid_d  = 1'b1;
                    cmd_opcode_d = rx_byte;
                end else begin
                    pend_op_d   = rx_byte;
                    arg_idx_d   = 2'd0;
                    cmd_state_d = CMD_ARG;
                end
            end else begin
                arg_idx_d = arg_idx_q + 2'd1;
                case (arg_idx_q)
                    2'd0:    arg_d[7:0]   = rx_byte;
                    2'd1:    arg_d[15:8]  = rx_byte;
                    2'd2:    arg_d[23:16] = rx_byte;
                    default: begin
                        cmd_valid_d  = 1'b1;
                        cmd_opcode_d = pend_op_q;
                        cmd_data_d   = {rx_byte, arg_q};
                        cmd_state_d  = CMD_OPCODE;
                    end
                endcase
            end
        end
`ifdef SPI_TIMEOUT_EN
        else if (timeout_hit) begin
            cmd_state_d = CMD_OPCODE;
            arg_idx_d   = 2'd0;
        end
`endif
    end

    // Transmit FSM: accept a word, then shift one byte per cs frame, MSB first.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_word_d    = tx_word_q;
        tx_idx_d     = tx_idx_q;
        tx_last_d    = tx_last_q;
        tx_sr_d      = tx_sr_q;
        tx_bit_d     = tx_bit_q;
        miso_d       = miso_q;
        data_ready_d = data_ready_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.tx_valid) begin
                    tx_word_d    = bus.tx_data;
                    // A zero (or out-of-range) count means a full word.
                    tx_last_d    = (bus.tx_bytes == '0 || bus.tx_bytes > TX_BYTES_W'(4))
                                   ? 2'd3 : 2'(bus.tx_bytes - TX_BYTES_W'(1));
                    tx_idx_d     = 2'd0;
                    data_ready_d = 1'b1;
                    tx_state_d   = TX_ARM;
                end
            end
            TX_ARM: begin
                if (cs_fall) begin
                    tx_sr_d    = cur_byte[6:0];
                    miso_d     = cur_byte[7];
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (cs_rise) begin
                    // Aborted byte is resent from bit 7 on the next frame.
                    miso_d     = 1'b0;
                    tx_state_d = TX_ARM;
                end else if (cs_low && sclk_rise) begin
                    if (tx_bit_q == 3'd7) begin
                        miso_d = 1'b0;
                        if (tx_idx_q == tx_last_q) begin
                            data_ready_d = 1'b0;
                            tx_state_d   = TX_IDLE;
                        end else begin
                            tx_idx_d   = tx_idx_q + 2'd1;
                            tx_state_d = TX_ARM;
                        end
                    end else begin
                        miso_d   = tx_sr_q[6];
                        tx_sr_d  = {tx_sr_q[5:0], 1'b0};
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                miso_d       = 1'b0;
                data_ready_d = 1'b0;
                tx_state_d   = TX_IDLE;
            end
        endcase
    end

    // State registers; cs synchronizer resets to the deselected level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b111;
            mosi_sync_q  <= 2'b00;
            rx_sr_q      <= '0;
            rx_cnt_q     <= '0;
            cmd_state_q  <= CMD_OPCODE;
            arg_idx_q    <= '0;
            pend_op_q    <= '0;
            arg_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= '0;
            cmd_data_q   <= '0;
            tx_state_q   <= TX_IDLE;
            tx_word_q    <= '0;
            tx_idx_q     <= '0;
            tx_last_q    <= '0;
            tx_sr_q      <= '0;
            tx_bit_q     <= '0;
            miso_q       <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            rx_sr_q      <= rx_sr_d;
            rx_cnt_q     <= rx_cnt_d;
            cmd_state_q  <= cmd_state_d;
            arg_idx_q    <= arg_idx_d;
            pend_op_q    <= pend_op_d;
            arg_q        <= arg_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_opcode_q <= cmd_opcode_d;
            cmd_data_q   <= cmd_data_d;
            tx_state_q   <= tx_state_d;
            tx_word_q    <= tx_word_d;
            tx_idx_q     <= tx_idx_d;
            tx_last_q    <= tx_last_d;
            tx_sr_q      <= tx_sr_d;
            tx_bit_q     <= tx_bit_d;
            miso_q       <= miso_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign bus.miso       = miso_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_opcode = cmd_opcode_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.tx_ready   = (tx_state_q == TX_IDLE);
    assign bus.dataReady  = data_ready_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as the PIC (SPI master) and the core.
// Latency: SPI bit period is 8 system clocks, 4 low / 4 high.
// Backpressure: tx words are offered only while tx_ready is high.
module tb_spi_slave;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   pulses      = 0;
    int   p0;
    int   nframes;
    logic [7:0] mi;
    logic [7:0] got [0:7];
    logic       m;

    spi_slave_if #(.TX_BYTES_W(3)) bus ();

`ifdef SPI_TIMEOUT_EN
    spi_slave #(.TX_BYTES_W(3), .TIMEOUT_CYCLES(100)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
`else
    spi_slave #(.TX_BYTES_W(3)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
`endif

    always #10 clock = ~clock;

    // Count command strobes, sampled away from the active edge.
    always @(negedge clock) if (bus.cmd_valid === 1'b1) pulses++;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic mbit);
        bus.mosi = b;
        tick(4);
        mbit = bus.miso;
        bus.sclk = 1'b1;
        tick(4);
        bus.sclk = 1'b0;
    endtask

    // One cs frame of nbits; returns the miso bits sampled at each rise.
    task automatic spi_frame(input logic [7:0] mo, input int nbits, output logic [7:0] mret);
        logic b;
        mret = 8'h00;
        bus.cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(mo[7-i], b);
            mret = {mret[6:0], b};
        end
        tick(4);
        bus.cs = 1'b1;
        tick(6);
    endtask

    task automatic send(input logic [7:0] mo);
        logic [7:0] dummy;
        spi_frame(mo, 8, dummy);
    endtask

    initial begin
        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.cs = 1'b1;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_bytes = '0;
        tick(3);
        check("rst_miso",      32'(bus.miso),       32'h0);
        check("rst_cmd_valid", 32'(bus.cmd_valid),  32'h0);
        check("rst_opcode",    32'(bus.cmd_opcode), 32'h0);
        check("rst_data",      bus.cmd_data,        32'h0);
        check("rst_dataReady", 32'(bus.dataReady),  32'h0);
        check("rst_tx_ready",  32'(bus.tx_ready),   32'h1);
        reset_n = 1'b1;
        tick(4);

        // Five 0x00 bytes are five short commands.
        p0 = pulses;
        for (int i = 0; i < 5; i++) send(8'h00);
        check("burst_pulses", 32'(pulses - p0), 32'd5);
        check("burst_opcode", 32'(bus.cmd_opcode), 32'h00);

        // Short command.
        p0 = pulses;
        send(8'h02);
        check("short_pulses", 32'(pulses - p0), 32'd1);
        check("short_opcode", 32'(bus.cmd_opcode), 32'h02);
        check("short_data",   bus.cmd_data, 32'h0);

        // Long command: strobe only after the fifth byte.
        p0 = pulses;
        send(8'hC0); send(8'hFF); send(8'h00); send(8'h00);
        check("long_no_early", 32'(pulses - p0), 32'd0);
        send(8'h00);
        check("long_pulses", 32'(pulses - p0), 32'd1);
        check("long_opcode", 32'(bus.cmd_opcode), 32'hC0);
        check("long_data",   bus.cmd_data, 32'h000000FF);

        // Transmit a four-byte word; a second offer while busy must be ignored.
        check("tx_ready_idle", 32'(bus.tx_ready), 32'h1);
        bus.tx_valid = 1'b1; bus.tx_data = 32'h534C4131; bus.tx_bytes = 3'd4;
        tick(1);
        bus.tx_valid = 1'b0;
        check("tx_dataReady_up", 32'(bus.dataReady), 32'h1);
        check("tx_ready_busy",   32'(bus.tx_ready),  32'h0);
        bus.tx_valid = 1'b1; bus.tx_data = 32'hDEADBEEF; bus.tx_bytes = 3'd1;
        tick(2);
        bus.tx_valid = 1'b0;
        p0 = pulses;
        nframes = 0;
        while (bus.dataReady === 1'b1 && nframes < 8) begin
            spi_frame(8'h7F, 8, mi);
            got[nframes] = mi;
            nframes++;
        end
        check("tx_frames", 32'(nframes), 32'd4);
        check("tx_byte0", 32'(got[0]), 32'h31);
        check("tx_byte1", 32'(got[1]), 32'h41);
        check("tx_byte2", 32'(got[2]), 32'h4C);
        check("tx_byte3", 32'(got[3]), 32'h53);
        check("tx_no_cmd",    32'(pulses - p0), 32'd0);
        check("tx_ready_end", 32'(bus.tx_ready), 32'h1);
        check("tx_miso_idle", 32'(bus.miso), 32'h0);

        // Two-byte word with the first frame cut after three bits.
        bus.tx_valid = 1'b1; bus.tx_data = 32'h0000A55A; bus.tx_bytes = 3'd2;
        tick(1);
        bus.tx_valid = 1'b0;
        spi_frame(8'h7F, 3, mi);
        check("tx2_partial", 32'(mi), 32'h02);
        nframes = 0;
        while (bus.dataReady === 1'b1 && nframes < 8) begin
            spi_frame(8'h7F, 8, mi);
            got[nframes] = mi;
            nframes++;
        end
        check("tx2_frames", 32'(nframes), 32'd2);
        check("tx2_byte0",  32'(got[0]), 32'h5A);
        check("tx2_byte1",  32'(got[1]), 32'hA5);

        // Receive abort: five bits of 0x81 then a clean 0x01.
        p0 = pulses;
        spi_frame(8'h81, 5, mi);
        send(8'h01);
        check("abort_pulses", 32'(pulses - p0), 32'd1);
        check("abort_opcode", 32'(bus.cmd_opcode), 32'h01);
        check("abort_data",   bus.cmd_data, 32'h000000FF);

        // Asynchronous reset in the middle of the third argument byte.
        send(8'h81); send(8'h11); send(8'h22);
        bus.cs = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
        #3 reset_n = 1'b0;
        #1;
        check("arst_opcode",    32'(bus.cmd_opcode), 32'h0);
        check("arst_data",      bus.cmd_data,        32'h0);
        check("arst_tx_ready",  32'(bus.tx_ready),   32'h1);
        check("arst_dataReady", 32'(bus.dataReady),  32'h0);
        tick(2);
        reset_n = 1'b1;
        bus.cs = 1'b1;
        tick(6);
        p0 = pulses;
        send(8'h02);
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);
        check("post_rst_opcode", 32'(bus.cmd_opcode), 32'h02);

`ifdef SPI_TIMEOUT_EN
        // Stale long command abandoned after the idle limit.
        p0 = pulses;
        send(8'h80); send(8'h02);
        tick(150);
        send(8'h01);
        check("timeout_pulses", 32'(pulses - p0), 32'd1);
        check("timeout_opcode", 32'(bus.cmd_opcode), 32'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
